// File: rtl/prog_ctr_stack.sv
// Fetch-stage program counter with a multi-program start table, an IDLE/ARM/RUN
// launch sequencer and a hardware call/return stack with sticky error reporting.
module prog_ctr_stack #(
    parameter int unsigned PC_W                           = 10,
    parameter int unsigned NUM_PROGS                      = 3,
    parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASES       = {10'd200, 10'd100, 10'd0},
    parameter int unsigned STACK_DEPTH                    = 4,
    localparam int unsigned IdxW   = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              BranchAbsEn,
    input  logic              BranchRelEn,
    input  logic              ALU_flag,
    input  logic              CallEn,
    input  logic              RetEn,
    input  logic [PC_W-1:0]   Target,
    input  logic              ClearErr,
    output logic [PC_W-1:0]   ProgCtr,
    output logic [IdxW-1:0]   ProgIdx,
    output logic              Running,
    output logic [DepthW-1:0] StackDepth,
    output logic              StackErr
);

    localparam int unsigned StkAW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StArm, StRun} seqState_t;

    seqState_t       state;
    logic [PC_W-1:0] stackMem [STACK_DEPTH];
    logic [PC_W-1:0] progBases [NUM_PROGS];
    logic [PC_W-1:0] pcInc;
    logic [PC_W-1:0] stackTop;
    logic [IdxW-1:0] nextIdx;
    logic            isRun;
    logic            doRet;
    logic            doCall;
    logic            stkEmpty;
    logic            stkFull;
    logic            pushEn;
    logic            errSet;

    // Unpack the flat start-address table; program 0 sits in the LSBs.
    for (genvar i = 0; i < NUM_PROGS; i++) begin : genBases
        assign progBases[i] = PROG_BASES[i*PC_W +: PC_W];
    end

    // Stack decode: Halt outranks Ret, Ret outranks Call, and none of them act outside RUN.
    always_comb begin
        isRun    = (state == StRun);
        pcInc    = ProgCtr + 1'b1;
        stkEmpty = (StackDepth == '0);
        stkFull  = (StackDepth == DepthW'(STACK_DEPTH));
        doRet    = isRun && !Halt && RetEn;
        doCall   = isRun && !Halt && !RetEn && CallEn;
        pushEn   = doCall && !stkFull;
        errSet   = (doRet && stkEmpty) || (doCall && stkFull);
        stackTop = stackMem[StkAW'(StackDepth - 1'b1)];
        nextIdx  = (ProgIdx == IdxW'(NUM_PROGS - 1)) ? '0 : ProgIdx + 1'b1;
        Running  = isRun;
    end

    // Return-address storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge Clk) begin
        if (pushEn) begin
            stackMem[StkAW'(StackDepth)] <= pcInc;
        end
    end

    // Sequencer, next-PC selection, stack depth and sticky error flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= StIdle;
            ProgCtr    <= '0;
            ProgIdx    <= '0;
            StackDepth <= '0;
            StackErr   <= 1'b0;
        end else begin
            // A new error in the same cycle wins over a clear request.
            if (errSet) begin
                StackErr <= 1'b1;
            end else if (ClearErr) begin
                StackErr <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (Start) begin
                        state   <= StArm;
                        ProgCtr <= progBases[ProgIdx];
                    end
                end
                StArm: begin
                    if (Halt) begin
                        state <= StIdle;
                    end else if (!Start) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (Halt) begin
                        state      <= StIdle;
                        StackDepth <= '0;
                        ProgIdx    <= nextIdx;
                    end else if (RetEn) begin
                        if (!stkEmpty) begin
                            ProgCtr    <= stackTop;
                            StackDepth <= StackDepth - 1'b1;
                        end else begin
                            ProgCtr <= pcInc;
                        end
                    end else if (CallEn) begin
                        if (!stkFull) begin
                            ProgCtr    <= Target;
                            StackDepth <= StackDepth + 1'b1;
                        end else begin
                            ProgCtr <= pcInc;
                        end
                    end else if (BranchAbsEn) begin
                        ProgCtr <= Target;
                    end else if (BranchRelEn && ALU_flag) begin
                        // Modulo-2^PC_W add is identical for a signed or unsigned offset.
                        ProgCtr <= ProgCtr + Target;
                    end else begin
                        ProgCtr <= pcInc;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr_stack.sv
// Self-checking bench for prog_ctr_stack: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_prog_ctr_stack;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Halt;
    logic       BranchAbsEn;
    logic       BranchRelEn;
    logic       ALU_flag;
    logic       CallEn;
    logic       RetEn;
    logic [9:0] Target;
    logic       ClearErr;
    logic [9:0] ProgCtr;
    logic [1:0] ProgIdx;
    logic       Running;
    logic [2:0] StackDepth;
    logic       StackErr;

    int nTests = 0;
    int nFail  = 0;

    // Behavioural model state: 0 = idle, 1 = arm, 2 = run.
    int   mPc;
    int   mIdx;
    int   mState;
    int   mStack[$];
    logic mErr;
    int   bases[3] = '{0, 100, 200};

    always #5 Clk = ~Clk;

    prog_ctr_stack #(
        .PC_W        (10),
        .NUM_PROGS   (3),
        .PROG_BASES  ({10'd200, 10'd100, 10'd0}),
        .STACK_DEPTH (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Halt        (Halt),
        .BranchAbsEn (BranchAbsEn),
        .BranchRelEn (BranchRelEn),
        .ALU_flag    (ALU_flag),
        .CallEn      (CallEn),
        .RetEn       (RetEn),
        .Target      (Target),
        .ClearErr    (ClearErr),
        .ProgCtr     (ProgCtr),
        .ProgIdx     (ProgIdx),
        .Running     (Running),
        .StackDepth  (StackDepth),
        .StackErr    (StackErr)
    );

    task automatic clear_inputs();
        Start = 0; Halt = 0; BranchAbsEn = 0; BranchRelEn = 0; ALU_flag = 0;
        CallEn = 0; RetEn = 0; Target = '0; ClearErr = 0;
    endtask

    task automatic model_reset();
        mPc = 0; mIdx = 0; mState = 0; mErr = 1'b0;
        mStack.delete();
    endtask

    // One clock of the specified behaviour, using the inputs currently driven.
    task automatic model_step();
        bit errSet = 0;
        int off;
        if (mState == 0) begin
            if (Start) begin
                mState = 1;
                mPc = bases[mIdx];
            end
        end else if (mState == 1) begin
            if (Halt) mState = 0;
            else if (!Start) mState = 2;
        end else begin
            if (Halt) begin
                mState = 0;
                mStack.delete();
                mIdx = (mIdx + 1) % 3;
            end else if (RetEn) begin
                if (mStack.size() > 0) mPc = mStack.pop_back();
                else begin errSet = 1; mPc = (mPc + 1) % 1024; end
            end else if (CallEn) begin
                if (mStack.size() < 4) begin
                    mStack.push_back((mPc + 1) % 1024);
                    mPc = int'(Target);
                end else begin
                    errSet = 1; mPc = (mPc + 1) % 1024;
                end
            end else if (BranchAbsEn) begin
                mPc = int'(Target);
            end else if (BranchRelEn && ALU_flag) begin
                off = (Target >= 10'd512) ? int'(Target) - 1024 : int'(Target);
                mPc = (mPc + off + 1024) % 1024;
            end else begin
                mPc = (mPc + 1) % 1024;
            end
        end
        if (errSet) mErr = 1'b1;
        else if (ClearErr) mErr = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 0; Start = 1;
        #12;
        nTests++; if (ProgCtr !== 10'd0) begin nFail++; $display("FAIL rst_pc got %0d exp 0", ProgCtr); end
        nTests++; if (Running !== 1'b0) begin nFail++; $display("FAIL rst_running got %b exp 0", Running); end
        nTests++; if (StackDepth !== 3'd0) begin nFail++; $display("FAIL rst_depth got %0d exp 0", StackDepth); end
        nTests++; if (StackErr !== 1'b0) begin nFail++; $display("FAIL rst_err got %b exp 0", StackErr); end
        nTests++; if (ProgIdx !== 2'd0) begin nFail++; $display("FAIL rst_idx got %0d exp 0", ProgIdx); end
        Reset = 1; Start = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            nTests++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || StackErr !== 1'b0) begin
                nFail++;
                $display("FAIL idle_hold cyc %0d got pc=%0d run=%b err=%b exp pc=0 run=0 err=0",
                         i, ProgCtr, Running, StackErr);
            end
        end
    endtask

    task automatic test_start();
        Start = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nTests++; if (ProgCtr !== 10'd0 || Running !== 1'b0) begin
                nFail++;
                $display("FAIL arm_hold cyc %0d got pc=%0d run=%b exp pc=0 run=0", i, ProgCtr, Running);
            end
        end
        Start = 0;
        tick();
        nTests++; if (Running !== 1'b1 || ProgCtr !== 10'd0) begin
            nFail++; $display("FAIL run_entry got pc=%0d run=%b exp pc=0 run=1", ProgCtr, Running);
        end
        tick();
        nTests++; if (ProgCtr !== 10'd1) begin nFail++; $display("FAIL run_inc1 got %0d exp 1", ProgCtr); end
        tick();
        nTests++; if (ProgCtr !== 10'd2) begin nFail++; $display("FAIL run_inc2 got %0d exp 2", ProgCtr); end
    endtask

    task automatic test_branch();
        BranchRelEn = 1; ALU_flag = 0; Target = 10'd5;
        tick();
        nTests++; if (ProgCtr !== 10'd3) begin nFail++; $display("FAIL rel_not_taken got %0d exp 3", ProgCtr); end
        ALU_flag = 1;
        tick();
        nTests++; if (ProgCtr !== 10'd8) begin nFail++; $display("FAIL rel_fwd got %0d exp 8", ProgCtr); end
        Target = 10'h3FE;
        tick();
        nTests++; if (ProgCtr !== 10'd6) begin nFail++; $display("FAIL rel_back got %0d exp 6", ProgCtr); end
        BranchAbsEn = 1; Target = 10'd10;
        tick();
        nTests++; if (ProgCtr !== 10'd10) begin nFail++; $display("FAIL abs_over_rel got %0d exp 10", ProgCtr); end
        clear_inputs();
    endtask

    task automatic test_call_ret();
        logic [9:0] expRet [4] = '{10'd301, 10'd201, 10'd101, 10'd12};
        CallEn = 1; Target = 10'd50;
        tick();
        nTests++; if (ProgCtr !== 10'd50 || StackDepth !== 3'd1) begin
            nFail++; $display("FAIL call got pc=%0d depth=%0d exp pc=50 depth=1", ProgCtr, StackDepth);
        end
        CallEn = 0; RetEn = 1;
        tick();
        nTests++; if (ProgCtr !== 10'd11 || StackDepth !== 3'd0) begin
            nFail++; $display("FAIL ret got pc=%0d depth=%0d exp pc=11 depth=0", ProgCtr, StackDepth);
        end
        RetEn = 0; CallEn = 1;
        for (int i = 1; i <= 4; i++) begin
            Target = 10'(i * 100);
            tick();
            nTests++; if (ProgCtr !== 10'(i * 100) || StackDepth !== 3'(i)) begin
                nFail++;
                $display("FAIL nest_call %0d got pc=%0d depth=%0d exp pc=%0d depth=%0d",
                         i, ProgCtr, StackDepth, i * 100, i);
            end
        end
        Target = 10'd500;
        tick();
        nTests++; if (ProgCtr !== 10'd401 || StackDepth !== 3'd4 || StackErr !== 1'b1) begin
            nFail++;
            $display("FAIL overflow got pc=%0d depth=%0d err=%b exp pc=401 depth=4 err=1",
                     ProgCtr, StackDepth, StackErr);
        end
        CallEn = 0; ClearErr = 1;
        tick();
        nTests++; if (StackErr !== 1'b0 || ProgCtr !== 10'd402) begin
            nFail++; $display("FAIL clear_err got err=%b pc=%0d exp err=0 pc=402", StackErr, ProgCtr);
        end
        ClearErr = 0; RetEn = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nTests++; if (ProgCtr !== expRet[i] || StackDepth !== 3'(3 - i)) begin
                nFail++;
                $display("FAIL pop %0d got pc=%0d depth=%0d exp pc=%0d depth=%0d",
                         i, ProgCtr, StackDepth, expRet[i], 3 - i);
            end
        end
        tick();
        nTests++; if (StackErr !== 1'b1 || ProgCtr !== 10'd13 || StackDepth !== 3'd0) begin
            nFail++;
            $display("FAIL underflow got err=%b pc=%0d depth=%0d exp err=1 pc=13 depth=0",
                     StackErr, ProgCtr, StackDepth);
        end
        clear_inputs();
        ClearErr = 1;
        tick();
        ClearErr = 0;
    endtask

    task automatic test_rotation();
        logic [9:0] expBase [3] = '{10'd100, 10'd200, 10'd0};
        for (int i = 0; i < 3; i++) begin
            Halt = 1;
            tick();
            Halt = 0;
            nTests++; if (Running !== 1'b0 || ProgIdx !== 2'((i + 1) % 3)) begin
                nFail++;
                $display("FAIL halt %0d got run=%b idx=%0d exp run=0 idx=%0d", i, Running, ProgIdx, (i + 1) % 3);
            end
            Start = 1;
            tick();
            Start = 0;
            tick();
            nTests++; if (ProgCtr !== expBase[i] || Running !== 1'b1) begin
                nFail++;
                $display("FAIL launch %0d got pc=%0d run=%b exp pc=%0d run=1", i, ProgCtr, Running, expBase[i]);
            end
        end
    endtask

    task automatic test_edge();
        BranchAbsEn = 1; Target = 10'd1023;
        tick();
        nTests++; if (ProgCtr !== 10'd1023) begin nFail++; $display("FAIL abs_max got %0d exp 1023", ProgCtr); end
        clear_inputs();
        tick();
        nTests++; if (ProgCtr !== 10'd0) begin nFail++; $display("FAIL pc_wrap got %0d exp 0", ProgCtr); end
        RetEn = 1;
        tick();
        RetEn = 0; CallEn = 1; Target = 10'd20;
        tick();
        Target = 10'd30;
        tick();
        clear_inputs();
        nTests++; if (StackDepth !== 3'd2 || StackErr !== 1'b1 || ProgCtr !== 10'd30) begin
            nFail++;
            $display("FAIL pre_reset got depth=%0d err=%b pc=%0d exp depth=2 err=1 pc=30",
                     StackDepth, StackErr, ProgCtr);
        end
        #2;
        Reset = 0;
        #1;
        nTests++; if (ProgCtr !== 10'd0 || Running !== 1'b0 || StackDepth !== 3'd0 ||
                      StackErr !== 1'b0 || ProgIdx !== 2'd0) begin
            nFail++;
            $display("FAIL async_reset got pc=%0d run=%b depth=%0d err=%b idx=%0d exp all 0",
                     ProgCtr, Running, StackDepth, StackErr, ProgIdx);
        end
        #3;
        Reset = 1;
        model_reset();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            Start       = ($urandom_range(99, 0) < 40);
            Halt        = ($urandom_range(99, 0) < 4);
            RetEn       = ($urandom_range(99, 0) < 20);
            CallEn      = ($urandom_range(99, 0) < 25);
            BranchAbsEn = ($urandom_range(99, 0) < 10);
            BranchRelEn = ($urandom_range(99, 0) < 30);
            ALU_flag    = ($urandom_range(99, 0) < 50);
            ClearErr    = ($urandom_range(99, 0) < 8);
            Target      = 10'($urandom);
            tick();
            nTests++; if (ProgCtr !== 10'(mPc)) begin
                nFail++; $display("FAIL rnd_pc cyc %0d got %0d exp %0d", c, ProgCtr, mPc);
            end
            nTests++; if (ProgIdx !== 2'(mIdx) || Running !== (mState == 2)) begin
                nFail++;
                $display("FAIL rnd_seq cyc %0d got idx=%0d run=%b exp idx=%0d run=%b",
                         c, ProgIdx, Running, mIdx, mState == 2);
            end
            nTests++; if (StackDepth !== 3'(mStack.size()) || StackErr !== mErr) begin
                nFail++;
                $display("FAIL rnd_stack cyc %0d got depth=%0d err=%b exp depth=%0d err=%b",
                         c, StackDepth, StackErr, mStack.size(), mErr);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_start();
        test_branch();
        test_call_ret();
        test_rotation();
        test_edge();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/prog_ctr_stack.md
Name: prog_ctr_stack

Overview:
Parametrised successor to the fetch-stage program counter. Adds generic PC width, a multi-program start table with round-robin program selection, an explicit IDLE/ARM/RUN sequencer, and a hardware call/return stack with overflow and underflow detection. Sits in instruction fetch and drives the instruction ROM address. Branch controls come from the control decoder, and the condition comes from the ALU flag.

Parameters:
PC_W, 10, program counter and target/offset width in bits
NUM_PROGS, 3, number of programs in the start table (>=1)
PROG_BASES, {10'd200,10'd100,10'd0}, packed NUM_PROGS*PC_W start addresses; program 0 is in the LSBs
STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
Clk  in  1  clock; all state changes on rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
Start  in  1  program launch request, level-sensitive
Halt  in  1  end current program, return to IDLE
BranchAbsEn  in  1  unconditional absolute jump to Target
BranchRelEn  in  1  relative branch, taken only when ALU_flag=1
ALU_flag  in  1  branch condition from ALU
CallEn  in  1  push return address, jump to Target
RetEn  in  1  pop return address into PC
Target  in  PC_W  absolute target, or two's-complement offset for relative branch
ClearErr  in  1  clears StackErr
ProgCtr  out  PC_W  current instruction address
ProgIdx  out  max(1,$clog2(NUM_PROGS))  program selected for the next or current launch
Running  out  1  high in RUN state
StackDepth  out  $clog2(STACK_DEPTH+1)  number of valid stack entries
StackErr  out  1  sticky overflow/underflow flag

Behaviour:
- Reset=0 (async):
  - ProgCtr=0, ProgIdx=0, Running=0, StackDepth=0, StackErr=0, state=IDLE.
  - Stack contents are don't-care.
- States: IDLE, ARM, RUN. Running=1 only in RUN.
- IDLE:
  - PC holds; all branch, call and return inputs are ignored.
  - Start=1 -> ARM, and PC <= PROG_BASES[ProgIdx].
- ARM:
  - PC holds the base address while Start=1.
  - Start=0 -> RUN with PC unchanged, so the first fetched instruction is the base address.
  - Halt in ARM -> IDLE; ProgIdx does not change.
- RUN next-PC priority, highest first:
  1. Halt: -> IDLE, PC holds, StackDepth <= 0, ProgIdx <= (ProgIdx+1) mod NUM_PROGS.
  2. RetEn:
     - Stack non-empty: PC <= top entry, depth -1.
     - Stack empty: StackErr <= 1, PC <= PC+1.
  3. CallEn:
     - Stack not full: push PC+1, PC <= Target, depth +1.
     - Stack full: StackErr <= 1, push suppressed, PC <= PC+1.
  4. BranchAbsEn: PC <= Target.
  5. BranchRelEn & ALU_flag: PC <= PC + Target, with Target treated as signed PC_W.
  6. Otherwise: PC <= PC+1.
- Start is ignored in RUN.
- All PC arithmetic is modulo 2^PC_W; wrap is silent (1023+1 -> 0 at PC_W=10).
- StackErr:
  - Set has priority over ClearErr in the same cycle.
  - ClearErr works in any state.
  - Errors are recorded only in RUN.
- One-cycle latency: every control input sampled at edge N is reflected on ProgCtr after edge N.
- StackDepth saturates at STACK_DEPTH and never goes below 0.

Test Plan:
- Reset held 0 with Start=1, then released; 3 idle cycles with Start=0 -> ProgCtr=0, Running=0, StackErr=0 throughout.
- Start=1 for 3 cycles, then 0 -> ProgCtr=0 during ARM; Running=1 after Start falls; next two edges give ProgCtr 1, 2.
- Branch checks starting from PC=2:
  - BranchRelEn=1, ALU_flag=0, Target=5 -> 3.
  - ALU_flag=1, Target=5 -> 8.
  - Target=10'h3FE -> 6.
  - BranchAbsEn=1 and BranchRelEn=1 with flag, Target=10 -> 10 (absolute wins).
- Call/return from PC=10:
  - CallEn, Target=50 -> PC=50, StackDepth=1.
  - RetEn -> PC=11, depth 0.
  - 5 nested calls -> 5th gives PC+1, StackErr=1, depth 4.
  - ClearErr -> 0.
  - 5 returns -> last gives StackErr=1.
- Program rotation: Halt -> IDLE, ProgIdx=1; Start pulse -> PC=100; Halt then Start -> PC=200; Halt then Start -> PC=0 (ProgIdx wraps to 0).
- Edge cases:
  - BranchAbsEn with Target=1023, then a plain cycle -> PC=0.
  - Reset asserted mid-RUN at depth 2 -> outputs reset immediately, without waiting for a clock edge.
